// File: rtl/iq_pkg.sv
// Shared types and defaults for the IQ sample packer.
package iq_pkg;

    localparam int IQ_IN_W   = 12;
    localparam int IQ_HALF_W = 16;

    typedef struct packed {
        logic [IQ_HALF_W-1:0] q;
        logic [IQ_HALF_W-1:0] i;
    } iq_pair_t;

    typedef enum logic {
        PH_I = 1'b0,
        PH_Q = 1'b1
    } phase_e;

endpackage

// File: rtl/iq_buf_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; read data is the registered
// entry at the read pointer, so the output has no path from din.
module iq_buf_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only visible once
    // the pointers say so, and a resettable array costs a flop per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/iq_packer.sv
// Pairs a non-stallable I,Q sample stream into sign-extended {Q,I} words,
// frames them with tlast and drops whole pairs when the output buffer overruns.
module iq_packer
    import iq_pkg::*;
#(
    parameter int IN_W      = IQ_IN_W,
    parameter int HALF_W    = IQ_HALF_W,
    parameter int FRAME_LEN = 256,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    input  logic [IN_W-1:0]     s_data,
    input  logic                en,
    input  logic                resync,
    output logic [2*HALF_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                overflow,
    output logic [15:0]         drop_cnt
);

    localparam int PW   = 2 * HALF_W;
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    function automatic logic [HALF_W-1:0] sext(input logic [IN_W-1:0] x);
        return HALF_W'($signed(x));
    endfunction

    phase_e          phase_q, phase_d;
    logic [IN_W-1:0] i_q, i_d;
    logic            pair_vld_q, pair_vld_d;
    logic [PW-1:0]   pair_q, pair_d;
    logic [FC_W-1:0] frm_cnt_q, frm_cnt_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic            valid_word;
    logic            buf_full, buf_empty, pop, push_ok, drop, tlast_in;
    logic [PW:0]     buf_dout;

    assign valid_word = s_valid && en;
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign push_ok    = pair_vld_q && (!buf_full || pop);
    assign drop       = pair_vld_q && !push_ok;
    assign tlast_in   = (frm_cnt_q == FC_W'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q    <= PH_I;
            i_q        <= '0;
            pair_vld_q <= 1'b0;
            pair_q     <= '0;
            frm_cnt_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            i_q        <= i_d;
            pair_vld_q <= pair_vld_d;
            pair_q     <= pair_d;
            frm_cnt_q  <= frm_cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        phase_d    = phase_q;
        i_d        = i_q;
        pair_vld_d = 1'b0;
        pair_d     = pair_q;
        frm_cnt_d  = frm_cnt_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // resync alone re-arms for I; with a word present that word is the I.
        if (resync) phase_d = PH_I;
        if (valid_word) begin
            if (resync || phase_q == PH_I) begin
                i_d     = s_data;
                phase_d = PH_Q;
            end else begin
                pair_vld_d = 1'b1;
                pair_d     = {sext(s_data), sext(i_q)};
                phase_d    = PH_I;
            end
        end

        if (push_ok) frm_cnt_d = tlast_in ? '0 : frm_cnt_q + 1'b1;

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    iq_buf_fifo #(
        .W     (PW + 1),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .din   ({tlast_in, pair_q}),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // Gate with empty so stale storage never shows on the bus.
    assign m_axis_tvalid = !buf_empty;
    assign m_axis_tdata  = buf_empty ? '0 : buf_dout[PW-1:0];
    assign m_axis_tlast  = !buf_empty && buf_dout[PW];
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_iq_packer.sv
// Directed bench for iq_packer with FRAME_LEN=4, BUF_DEPTH=4.
module tb_iq_packer;
    import iq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [11:0] s_data;
    logic        en;
    logic        resync;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    iq_packer #(
        .IN_W      (12),
        .HALF_W    (16),
        .FRAME_LEN (4),
        .BUF_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .en            (en),
        .resync        (resync),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    function automatic logic [31:0] exp_pair(input logic [11:0] i, input logic [11:0] q);
        iq_pair_t p;
        p.i = {{4{i[11]}}, i};
        p.q = {{4{q[11]}}, q};
        return p;
    endfunction

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [11:0] w);
        s_valid = 1'b1;
        s_data  = w;
        step();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; en = 1'b1;
        resync = 1'b0; m_tready = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (m_tvalid !== 1'b0) begin n_miss++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        n_vec++; if (m_tlast !== 1'b0) begin n_miss++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
        n_vec++; if (m_tdata !== 32'h0) begin n_miss++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
        n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_vec++; if (drop_cnt !== 16'h0) begin n_miss++; $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); end
    endtask

    task automatic test_pairing();
        do_reset();
        m_tready = 1'b1;
        send(12'h7FF);
        send(12'h800);
        n_vec++; if (m_tvalid !== 1'b0) begin n_miss++; $display("FAIL pair_early_tvalid got %b want 0", m_tvalid); end
        step();
        n_vec++; if (m_tvalid !== 1'b1) begin n_miss++; $display("FAIL pair_tvalid got %b want 1", m_tvalid); end
        n_vec++; if (m_tdata !== 32'hF800_07FF) begin n_miss++; $display("FAIL pair_tdata got %h want F80007FF", m_tdata); end
        n_vec++; if (m_tlast !== 1'b0) begin n_miss++; $display("FAIL pair_tlast got %b want 0", m_tlast); end
        step();
        n_vec++; if (m_tvalid !== 1'b0) begin n_miss++; $display("FAIL pair_single_beat got %b want 0", m_tvalid); end
        n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL pair_overflow got %b want 0", overflow); end
    endtask

    task automatic test_framing();
        int nb = 0;
        logic [11:0] wi, wq;
        do_reset();
        m_tready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (m_tvalid) begin
                wi = 12'(nb * 3 + 1);
                wq = 12'h800 | 12'(nb);
                n_vec++; if (m_tdata !== exp_pair(wi, wq)) begin n_miss++; $display("FAIL frame_tdata beat %0d got %h want %h", nb, m_tdata, exp_pair(wi, wq)); end
                n_vec++; if (m_tlast !== (nb % 4 == 3)) begin n_miss++; $display("FAIL frame_tlast beat %0d got %b want %b", nb, m_tlast, (nb % 4 == 3)); end
                nb++;
            end
            if (c < 18) begin
                s_valid = 1'b1;
                s_data  = (c % 2 == 0) ? 12'((c / 2) * 3 + 1) : (12'h800 | 12'(c / 2));
            end else begin
                s_valid = 1'b0;
            end
            step();
        end
        n_vec++; if (nb !== 9) begin n_miss++; $display("FAIL frame_beats got %0d want 9", nb); end
    endtask

    task automatic test_overrun();
        int nb = 0;
        logic [31:0] first;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send(12'h100 + 12'(k));
            send(12'hF00 + 12'(k));
        end
        step(); step();
        n_vec++; if (m_tvalid !== 1'b1) begin n_miss++; $display("FAIL ovr_tvalid got %b want 1", m_tvalid); end
        n_vec++; if (overflow !== 1'b1) begin n_miss++; $display("FAIL ovr_overflow got %b want 1", overflow); end
        n_vec++; if (drop_cnt !== 16'd2) begin n_miss++; $display("FAIL ovr_drop_cnt got %0d want 2", drop_cnt); end
        first = exp_pair(12'h100, 12'hF00);
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (m_tdata !== first) begin n_miss++; $display("FAIL ovr_stall_tdata got %h want %h", m_tdata, first); end
            step();
        end
        m_tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_tvalid) begin
                n_vec++; if (m_tdata !== exp_pair(12'h100 + 12'(nb), 12'hF00 + 12'(nb))) begin n_miss++; $display("FAIL ovr_drain beat %0d got %h", nb, m_tdata); end
                nb++;
            end
            step();
        end
        n_vec++; if (nb !== 4) begin n_miss++; $display("FAIL ovr_beats got %0d want 4", nb); end
        n_vec++; if (drop_cnt !== 16'd2) begin n_miss++; $display("FAIL ovr_drop_hold got %0d want 2", drop_cnt); end
    endtask

    task automatic test_full_pop();
        int nb = 0;
        logic [31:0] last;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(12'h010 + 12'(k));
            send(12'h020 + 12'(k));
        end
        // Fifth pair sits in the pairing stage; pop on the edge it is pushed.
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        n_vec++; if (drop_cnt !== 16'd0) begin n_miss++; $display("FAIL fullpop_drop_cnt got %0d want 0", drop_cnt); end
        n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
        n_vec++; if (m_tdata !== exp_pair(12'h011, 12'h021)) begin n_miss++; $display("FAIL fullpop_head got %h want %h", m_tdata, exp_pair(12'h011, 12'h021)); end
        m_tready = 1'b1;
        last = '0;
        for (int c = 0; c < 8; c++) begin
            if (m_tvalid) begin last = m_tdata; nb++; end
            step();
        end
        n_vec++; if (nb !== 4) begin n_miss++; $display("FAIL fullpop_beats got %0d want 4", nb); end
        n_vec++; if (last !== exp_pair(12'h014, 12'h024)) begin n_miss++; $display("FAIL fullpop_last got %h want %h", last, exp_pair(12'h014, 12'h024)); end
    endtask

    task automatic test_resync_en();
        do_reset();
        m_tready = 1'b1;
        // resync on an idle cycle after a held I.
        send(12'h555);
        resync = 1'b1; step(); resync = 1'b0;
        send(12'h123);
        send(12'h9AB);
        step();
        n_vec++; if (m_tdata !== exp_pair(12'h123, 12'h9AB)) begin n_miss++; $display("FAIL resync_tdata got %h want %h", m_tdata, exp_pair(12'h123, 12'h9AB)); end
        step(); step();
        n_vec++; if (m_tvalid !== 1'b0) begin n_miss++; $display("FAIL resync_extra got %b want 0", m_tvalid); end
        // resync coinciding with a word: that word becomes I.
        send(12'h0AA);
        resync = 1'b1; send(12'h0BB); resync = 1'b0;
        send(12'hCCC);
        step();
        n_vec++; if (m_tdata !== exp_pair(12'h0BB, 12'hCCC)) begin n_miss++; $display("FAIL resync_same got %h want %h", m_tdata, exp_pair(12'h0BB, 12'hCCC)); end
        step();
        // en low for 3 cycles between I and Q.
        send(12'h321);
        en = 1'b0; s_valid = 1'b1; s_data = 12'hEEE;
        step(); step(); step();
        en = 1'b1;
        send(12'hABC);
        n_vec++; if (m_tvalid !== 1'b0) begin n_miss++; $display("FAIL en_hold_early got %b want 0", m_tvalid); end
        step();
        n_vec++; if (m_tdata !== exp_pair(12'h321, 12'hABC)) begin n_miss++; $display("FAIL en_hold_tdata got %h want %h", m_tdata, exp_pair(12'h321, 12'hABC)); end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(12'h001); send(12'h002);
        send(12'h003); send(12'h004);
        send(12'h777);
        step();
        n_vec++; if (m_tvalid !== 1'b1) begin n_miss++; $display("FAIL mid_pre_tvalid got %b want 1", m_tvalid); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_vec++; if (m_tvalid !== 1'b0) begin n_miss++; $display("FAIL mid_tvalid got %b want 0", m_tvalid); end
        n_vec++; if (drop_cnt !== 16'd0) begin n_miss++; $display("FAIL mid_drop_cnt got %0d want 0", drop_cnt); end
        m_tready = 1'b1;
        send(12'h0F1);
        send(12'h0F2);
        step();
        n_vec++; if (m_tdata !== exp_pair(12'h0F1, 12'h0F2)) begin n_miss++; $display("FAIL mid_repair got %h want %h", m_tdata, exp_pair(12'h0F1, 12'h0F2)); end
        step();
    endtask

    initial begin
        test_reset();
        test_pairing();
        test_framing();
        test_overrun();
        test_full_pop();
        test_resync_en();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
